// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - prefetching instruction fetch unit with a BUF_DEPTH-entry buffer
// Optional halt-on-ECALL behaviour is enabled by defining FETCH_HALT_ON_ECALL_EN.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic [31:0] ReadAddress,
   input  logic [31:0] Instruction,
   output logic        FetchValid,
   input  logic        FetchReady,
   output logic [31:0] FetchInstruction,
   output logic [31:0] FetchPC,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   output logic        Halted
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

   logic [31:0]      fetch_addr;
   logic [31:0]      target_aligned;
   logic [31:0]      pc_mem    [BUF_DEPTH];
   logic [31:0]      instr_mem [BUF_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             pop;
   logic             push;
   logic             halted;

   assign target_aligned = BranchTarget & 32'hFFFF_FFFC;
   assign empty          = (count == '0);
   assign full           = (count == FULL_CNT);
   assign pop            = !empty && FetchReady;
   // A full buffer still accepts a new word when its head leaves on the same edge.
   assign push           = !halted && (!full || pop);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         fetch_addr <= RESET_PC;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (BranchTaken) begin
         fetch_addr <= target_aligned;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else begin
         if (push) begin
            pc_mem[tail]    <= fetch_addr;
            instr_mem[tail] <= Instruction;
            tail            <= tail + PTR_W'(1);
            fetch_addr      <= fetch_addr + 32'd4;
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

`ifdef FETCH_HALT_ON_ECALL_EN
   logic halt_q;

   // The ECALL word itself is buffered; only the fetches after it are suppressed.
   always_ff @(posedge Clock) begin
      if (Reset || BranchTaken) begin
         halt_q <= 1'b0;
      end else if (push && (Instruction == 32'h0000_0073)) begin
         halt_q <= 1'b1;
      end
   end
   assign halted = halt_q;
`else
   assign halted = 1'b0;
`endif

   assign ReadAddress      = fetch_addr;
   assign FetchValid       = !empty;
   assign FetchInstruction = instr_mem[head];
   assign FetchPC          = pc_mem[head];
   assign Halted           = halted;

endmodule
